// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding and FSM state encoding for the sequential ALU.
// The opcode values are the same as the ones the combinational 8-bit ALU used.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between instruction decode and
// the sequential ALU.
//   master (decode side): drives in_valid, opcode, a, b, out_ready
//   slave  (ALU side)   : drives in_ready, out_valid, result, flags, busy
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             overflow;
    logic             negative;
    logic             busy;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, carry_out, zero, overflow, negative, busy
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, carry_out, zero, overflow, negative, busy
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU operations.
//   opcode, a, b        : operation select and operands
//   result              : operation result
//   carry_out, overflow : carry/borrow and signed overflow (ADD/SUB only)
// MUL produces zeros here; it is never loaded from this block. SHL passes a
// through unchanged, which is exactly the shift-by-zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is set exactly when a < b unsigned.
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result    = sum_ext[WIDTH-1:0];
                carry_out = sum_ext[WIDTH];
                overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result    = diff_ext[WIDTH-1:0];
                carry_out = diff_ext[WIDTH];
                overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: result = a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshake and registered result/flags.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : alu_seq_if slave (operands in, result/flags out, busy)
// Single-cycle ops resolve through alu_core on the accepting edge. MUL is an
// unsigned shift-add over WIDTH cycles; SHL shifts one bit per cycle.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// EXEC  | iterating MUL/SHL, busy=1, in_ready=0
// DONE  | result/flags valid and held until out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t               state_q, state_d;
    logic                 in_ready;
    logic                 accept;
    logic                 start_iter;
    logic                 last_step;
    logic [SHAMT_W-1:0]   shamt;

    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     sh_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0]   acc_step;

    logic [WIDTH-1:0]     result_q;
    logic                 carry_q;
    logic                 zero_q;
    logic                 ovf_q;
    logic                 neg_q;

    logic [WIDTH-1:0]     core_result;
    logic                 core_carry;
    logic                 core_ovf;

    logic                 ld_en;
    logic [WIDTH-1:0]     ld_result;
    logic                 ld_carry;
    logic                 ld_ovf;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode    (bus.opcode),
        .a         (bus.a),
        .b         (bus.b),
        .result    (core_result),
        .carry_out (core_carry),
        .overflow  (core_ovf)
    );

    assign shamt      = bus.b[SHAMT_W-1:0];
    assign start_iter = (bus.opcode == OP_MUL) || ((bus.opcode == OP_SHL) && (shamt != '0));
    assign accept     = bus.in_valid && in_ready;
    // cnt_q is a down-counter loaded with (steps-1); zero marks the final step.
    assign last_step  = (state_q == EXEC) && (cnt_q == '0);
    assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = start_iter ? EXEC : DONE;
                end
            end
            EXEC: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                in_ready      = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        state_d = start_iter ? EXEC : DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = in_ready;

    // Selects what (if anything) lands in the output registers this cycle.
    always_comb begin
        ld_en     = 1'b0;
        ld_result = core_result;
        ld_carry  = core_carry;
        ld_ovf    = core_ovf;
        if (accept && !start_iter) begin
            ld_en = 1'b1;
        end else if (last_step) begin
            ld_en = 1'b1;
            if (op_q == OP_MUL) begin
                ld_result = acc_step[WIDTH-1:0];
                ld_carry  = |acc_step[2*WIDTH-1:WIDTH];
                ld_ovf    = |acc_step[2*WIDTH-1:WIDTH];
            end else begin
                ld_result = {sh_q[WIDTH-2:0], 1'b0};
                ld_carry  = sh_q[WIDTH-1];
                ld_ovf    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_ADD;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.opcode;
                if (bus.opcode == OP_MUL) begin
                    acc_q    <= '0;
                    mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                    mplier_q <= bus.b;
                    cnt_q    <= SHAMT_W'(WIDTH - 1);
                end else if (start_iter) begin
                    sh_q  <= bus.a;
                    cnt_q <= shamt - SHAMT_W'(1);
                end
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q - SHAMT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_q    <= acc_step;
                    mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                end else begin
                    sh_q <= {sh_q[WIDTH-2:0], 1'b0};
                end
            end
            if (ld_en) begin
                result_q <= ld_result;
                carry_q  <= ld_carry;
                ovf_q    <= ld_ovf;
                zero_q   <= (ld_result == '0);
                neg_q    <= ld_result[WIDTH-1];
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.negative  = neg_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, sequential successor to the 8-bit combinational ALU (alu_control).
- Accepts operand pairs through a valid/ready handshake and registers the result and flags.
- Keeps the existing opcode encoding, generalised to WIDTH bits.
- Adds two multi-cycle operations: shift-add multiply and iterative shift-left.
- Sits between the instruction-decode stage and the writeback/flag register.

Parameters:
- WIDTH, 8, operand/result width; must be a power of 2 and at least 4.
- SHAMT_W, $clog2(WIDTH), derived localparam; width of the shift-amount field.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  opcode/a/b valid
- in_ready  out  1  block can accept an operation
- opcode  in  3  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- carry_out  out  1  carry/borrow/overflow-of-product flag
- zero  out  1  result == 0
- overflow  out  1  signed overflow flag
- negative  out  1  result[WIDTH-1]
- busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset is synchronous active-high on clk. On reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all flags 0. Reset aborts any in-flight operation; the pending result is discarded.
- Accept occurs when in_valid && in_ready. opcode, a and b are captured on the accepting edge.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A result handoff and a new accept may happen in the same cycle.
- States:
  - IDLE: on accept of a single-cycle op, go to DONE. On accept of MUL, or SHL with amount != 0, go to EXEC.
  - EXEC: busy=1, in_ready=0. Iterate one step per cycle; go to DONE on the final step.
  - DONE: out_valid=1 and outputs are held stable until out_ready. On out_ready: go to IDLE, or take a new accept in the same cycle and branch as from IDLE.
- Opcodes and flags:
  - 000 ADD: result = a+b mod 2^WIDTH. carry_out = bit WIDTH of the sum. overflow = signed overflow.
  - 001 SUB: result = a-b. carry_out = borrow (a<b unsigned). overflow = signed overflow.
  - 100 AND, 101 OR, 110 XOR: carry_out=0, overflow=0.
  - 111 NOT: result = ~a; b ignored. carry_out=0, overflow=0.
  - 010 MUL: unsigned shift-add over exactly WIDTH EXEC cycles. result = low WIDTH bits of the product. carry_out = overflow = (upper WIDTH bits != 0).
  - 011 SHL: logical left shift of a by k = b[SHAMT_W-1:0] (upper bits of b ignored). One bit per EXEC cycle, k cycles. carry_out = last bit shifted out, 0 when k=0. overflow=0.
- zero and negative are computed from the final result for all ops.
- Latency from accept edge to out_valid:
  - single-cycle ops and SHL with k=0: 1 cycle
  - MUL: WIDTH+1 cycles
  - SHL: k+1 cycles
- Inputs are don't-care while busy. Any in_valid assertion while in_ready=0 is ignored and not queued.
- The datapath holds its own internal operand/accumulator registers (2*WIDTH for MUL). No combinational path exists from inputs to result or flags.

Decomposition:
- alu_pkg: opcode localparams (OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_SHL=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110, OP_NOT=3'b111) and state encoding (IDLE, EXEC, DONE).
- Sub-module alu_core: purely combinational, parametrised WIDTH. Implements the single-cycle ops and their flags.
- alu_seq instantiates alu_core and holds the FSM, the MUL/SHL iteration logic and the output registers.

Test Plan (WIDTH=8):
1. ADD a=0x7F, b=0x01, out_ready=1 -> out_valid 1 cycle after accept; result=0x80, overflow=1, negative=1, carry_out=0, zero=0.
2. SUB 0x05-0x05 -> result=0x00, zero=1, carry_out=0. Then SUB 0x03-0x05 -> result=0xFE, carry_out=1, negative=1, overflow=0.
3. MUL 0x10*0x11 -> busy=1 and in_ready=0 for 8 cycles; out_valid 9 cycles after accept; result=0x10, carry_out=1, overflow=1.
4. SHL a=0x81, b=0x0B (k=3) -> out_valid 4 cycles after accept; result=0x08, carry_out=0. SHL a=0x81, b=0x01 -> result=0x02, carry_out=1, latency 1+1.
5. Backpressure: after ADD 0x01+0x01, hold out_ready=0 for 5 cycles -> result=0x02 and flags stable, in_ready=0. Then raise out_ready with in_valid (XOR 0xF0^0xFF) in the same cycle -> accepted; next cycle result=0x0F.
6. Assert rst on the 4th EXEC cycle of a MUL -> next cycle state=IDLE, in_ready=1, out_valid=0, busy=0, result=0. A following NOT a=0x00 -> result=0xFF, negative=1.
